// File: rtl/debounce_multi_pkg.sv
// Shared state encoding and width helpers for the multi-channel switch debouncer.
package debounce_multi_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

  // Bits needed to hold 0..value-1, never narrower than one bit.
  function automatic int minWidth(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: four-state FSM, tick counter, registered level and edge pulses.
module debounce_ch
  import debounce_multi_pkg::*;
#(
  parameter int N_TICKS = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  input  logic tick_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = minWidth(N_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_TICKS - 1);

  db_state_e     r_state;
  db_state_e     w_stateNext;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntNext;
  logic          w_dbNext;
  logic          r_db;
  logic          r_rise;
  logic          r_fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // A level reversal is tested before the tick, so it wins when both arrive together.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      STABLE_LO: begin
        if (sw_i) begin
          w_stateNext = WAIT_HI;
          w_cntNext   = '0;
        end
      end
      WAIT_HI: begin
        if (!sw_i) begin
          w_stateNext = STABLE_LO;
        end else if (tick_i) begin
          if (r_cnt == CNT_LAST) begin
            w_stateNext = STABLE_HI;
          end else begin
            w_cntNext = r_cnt + 1'b1;
          end
        end
      end
      STABLE_HI: begin
        if (!sw_i) begin
          w_stateNext = WAIT_LO;
          w_cntNext   = '0;
        end
      end
      WAIT_LO: begin
        if (sw_i) begin
          w_stateNext = STABLE_HI;
        end else if (tick_i) begin
          if (r_cnt == CNT_LAST) begin
            w_stateNext = STABLE_LO;
          end else begin
            w_cntNext = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = STABLE_LO;
        w_cntNext   = '0;
      end
    endcase
  end

  always_comb begin
    w_dbNext = (r_state == STABLE_HI) || (r_state == WAIT_LO);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_db   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_db   <= w_dbNext;
      r_rise <= w_dbNext & ~r_db;
      r_fall <= ~w_dbNext & r_db;
    end
  end

  assign db_o   = r_db;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// File: rtl/debounce_multi.sv
// N-channel switch debouncer sharing one tick generator across all channels.
// Define DEBOUNCE_MULTI_SYNC_EN to add a 2-flop input synchroniser per channel.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int N_TICKS  = 3,
  parameter int TICK_DIV = 100000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] sw_i,
  output logic [N_CH-1:0] db_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic            tick_o
);

  localparam int DW = minWidth(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0]   r_div;
  logic            r_tick;
  logic [N_CH-1:0] w_sw;

  // With TICK_DIV == 1 the divider stays at zero and the tick fires every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_tick <= (r_div == DIV_LAST);
    end
  end

`ifdef DEBOUNCE_MULTI_SYNC_EN
  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sw = r_sync2;
`else
  assign w_sw = sw_i;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .N_TICKS(N_TICKS)
    ) u_ch (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .sw_i  (w_sw[g]),
      .tick_i(r_tick),
      .db_o  (db_o[g]),
      .rise_o(rise_o[g]),
      .fall_o(fall_o[g])
    );
  end

  assign tick_o = r_tick;

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus random switch activity
// compared every cycle against a run-length reference model.
module tb_debounce_multi;

  localparam int N_CH     = 2;
  localparam int N_TICKS  = 3;
  localparam int TICK_DIV = 4;
`ifdef DEBOUNCE_MULTI_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT_MIN = (N_TICKS - 1) * TICK_DIV + 2 + SYNC_LAT;
  localparam int LAT_MAX = N_TICKS * TICK_DIV + 1 + SYNC_LAT;

  logic            clk_i  = 1'b0;
  logic            rst_ni = 1'b0;
  logic [N_CH-1:0] sw_i   = '0;
  logic [N_CH-1:0] db_o;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] fall_o;
  logic            tick_o;

  int errors = 0;
  int checks = 0;

  debounce_multi #(
    .N_CH    (N_CH),
    .N_TICKS (N_TICKS),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .sw_i  (sw_i),
    .db_o  (db_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .tick_o(tick_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: accepted level per channel plus the number of ticks seen
  // since the current opposing run of input samples began.
  int              k;
  logic [N_CH-1:0] mLevel;
  logic [N_CH-1:0] mPending;
  int              mCnt [N_CH];
  logic [N_CH-1:0] mDb;
  logic [N_CH-1:0] mRise;
  logic [N_CH-1:0] mFall;
  logic            mTick;
  logic [N_CH-1:0] mSync0;
  logic [N_CH-1:0] mSync1;

  task automatic modelReset();
    k        = 0;
    mLevel   = '0;
    mPending = '0;
    mDb      = '0;
    mRise    = '0;
    mFall    = '0;
    mTick    = 1'b0;
    mSync0   = '0;
    mSync1   = '0;
    for (int c = 0; c < N_CH; c++) mCnt[c] = 0;
  endtask

  task automatic modelEdge(input logic [N_CH-1:0] sw);
    logic            tickIn;
    logic [N_CH-1:0] oldLevel;
    logic [N_CH-1:0] swEff;
    tickIn   = mTick;
    oldLevel = mLevel;
    if (SYNC_LAT > 0) begin
      swEff  = mSync1;
      mSync1 = mSync0;
      mSync0 = sw;
    end else begin
      swEff = sw;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (swEff[c] == mLevel[c]) begin
        mPending[c] = 1'b0;
      end else if (!mPending[c]) begin
        mPending[c] = 1'b1;
        mCnt[c]     = 0;
      end else if (tickIn) begin
        mCnt[c]++;
        if (mCnt[c] == N_TICKS) begin
          mLevel[c]   = swEff[c];
          mPending[c] = 1'b0;
        end
      end
    end
    mRise = oldLevel & ~mDb;
    mFall = ~oldLevel & mDb;
    mDb   = oldLevel;
    k++;
    mTick = ((k % TICK_DIV) == 0);
  endtask

  task automatic check(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic checkOutput();
    check("db", db_o, mDb);
    check("rise", rise_o, mRise);
    check("fall", fall_o, mFall);
    check("tick", {{(N_CH-1){1'b0}}, tick_o}, {{(N_CH-1){1'b0}}, mTick});
  endtask

  // Called at a falling edge; drives sw for n cycles, checking after each rising edge.
  task automatic applyStimulus(input logic [N_CH-1:0] sw, input int n);
    repeat (n) begin
      sw_i = sw;
      @(posedge clk_i);
      modelEdge(sw);
      #1;
      checkOutput();
      @(negedge clk_i);
    end
  endtask

  task automatic holdUntil(input logic [N_CH-1:0] sw, input int ch, input logic val,
                           input int maxCycles, output int lat, output int pulses);
    lat    = -1;
    pulses = 0;
    for (int i = 0; i < maxCycles; i++) begin
      applyStimulus(sw, 1);
      if (lat < 0 && db_o[ch] === val) lat = i;
      pulses += val ? int'(rise_o[ch]) : int'(fall_o[ch]);
    end
  endtask

  initial begin
    int              lat;
    int              pulses;
    int              bound;
    int              hold [N_CH];
    logic [N_CH-1:0] cur;

    $display("[TB] debounce_multi bench, SYNC_LAT=%0d latency window %0d..%0d", SYNC_LAT, LAT_MIN, LAT_MAX);
    modelReset();

    // Reset held with switches high: everything stays cleared.
    rst_ni = 1'b0;
    sw_i   = '1;
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput();
    @(negedge clk_i);
    check("resetDb", db_o, '0);
    sw_i   = '0;
    rst_ni = 1'b1;
    applyStimulus('0, 12);

    // Clean press on channel 0.
    holdUntil(2'b01, 0, 1'b1, 20, lat, pulses);
    checkRange("pressLat", lat, LAT_MIN, LAT_MAX);
    checkRange("pressRiseCount", pulses, 1, 1);
    check("pressOtherCh", {1'b0, db_o[1]}, 2'b00);

    // Release with a one-cycle re-assertion mid-wait: no fall expected.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b00, 1);
      pulses += int'(fall_o[0]);
    end
    applyStimulus(2'b01, 1);
    pulses += int'(fall_o[0]);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b01, 1);
      pulses += int'(fall_o[0]);
    end
    checkRange("reassertFallCount", pulses, 0, 0);
    check("reassertDb", {1'b0, db_o[0]}, 2'b01);

    // Full release.
    holdUntil(2'b00, 0, 1'b0, 20, lat, pulses);
    checkRange("releaseLat", lat, LAT_MIN, LAT_MAX);
    checkRange("releaseFallCount", pulses, 1, 1);

    // Bounce: high 6, low 1, then high and held.
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b01, 1);
      pulses += int'(db_o[0]);
    end
    applyStimulus(2'b00, 1);
    pulses += int'(db_o[0]);
    checkRange("bounceDbStaysLow", pulses, 0, 0);
    holdUntil(2'b01, 0, 1'b1, 20, lat, pulses);
    checkRange("bounceLat", lat, LAT_MIN, LAT_MAX);
    checkRange("bounceRiseCount", pulses, 1, 1);
    holdUntil(2'b00, 0, 1'b0, 20, lat, pulses);

    // Reset mid-wait (count at 2), then full latency again after release.
    bound = 0;
    applyStimulus(2'b01, 1);
    while (!(mPending[0] && mCnt[0] == 2) && bound < 30) begin
      applyStimulus(2'b01, 1);
      bound++;
    end
    checkRange("reachWaitCnt2", bound, 0, 29);
    rst_ni = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk_i);
    checkOutput();
    rst_ni = 1'b1;
    holdUntil(2'b01, 0, 1'b1, 20, lat, pulses);
    checkRange("postResetLat", lat, LAT_MIN, LAT_MAX);
    checkRange("postResetRiseCount", pulses, 1, 1);

    // Random independent activity on both channels.
    cur = sw_i;
    for (int c = 0; c < N_CH; c++) hold[c] = $urandom_range(1, 16);
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (hold[c] == 0) begin
          cur[c]  = ~cur[c];
          hold[c] = $urandom_range(1, 16);
        end
        hold[c]--;
      end
      applyStimulus(cur, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
